// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes, functs, ALU codes.
// HALT exists only when ILLEGAL_OP_TRAP_EN is defined.
package mips_ctrl_pkg;

`ifdef ILLEGAL_OP_TRAP_EN
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECUTE  = 4'd6,  S_ALUWB   = 4'd7,
        S_BEQ      = 4'd8,  S_ADDIEXEC = 4'd9,  S_ADDIWB   = 4'd10, S_JUMP    = 4'd11,
        S_HALT     = 4'd12
    } state_t;
`else
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECUTE  = 4'd6,  S_ALUWB   = 4'd7,
        S_BEQ      = 4'd8,  S_ADDIEXEC = 4'd9,  S_ADDIWB   = 4'd10, S_JUMP    = 4'd11
    } state_t;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's aluop plus the R-type funct field to alu_control.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // aluop 11 is unused by the FSM and falls back to add
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore main-decoder FSM for the multicycle MIPS core plus the ALU decoder instance.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes into a sticky HALT state.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       mem_to_reg,
    output logic       reg_dest,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic       ir_write,
    output logic       mem_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal_op
);

    state_t     state;
    state_t     next_state;
    logic [1:0] aluop;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; opcode is only consulted while the IR is stable
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      next_state = S_HALT;
`else
                    default:      next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    next_state = S_MEMREAD;
                end else begin
                    next_state = S_MEMWRITE;
                end
            end
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTE:  next_state = S_ALUWB;
            S_ADDIEXEC: next_state = S_ADDIWB;
`ifdef ILLEGAL_OP_TRAP_EN
            S_HALT:     next_state = S_HALT;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    // Moore output decode; reset forces every strobe and select low
    always_comb begin
        mem_to_reg = 1'b0;
        reg_dest   = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        aluop      = ALUOP_ADD;
        if (reset) begin
            aluop = ALUOP_ADD;
        end else begin
            case (state)
                S_FETCH: begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR, S_ADDIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMREAD: i_or_d = 1'b1;
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    aluop     = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    reg_dest  = 1'b1;
                    reg_write = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = 1'b1;
                    aluop     = ALUOP_SUB;
                    pc_src    = 2'b01;
                    branch    = 1'b1;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                default: aluop = ALUOP_ADD;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .alu_control (alu_control)
    );

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_flag;

    // Sticky trap flag, raised on HALT entry and cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_flag <= 1'b0;
        end else if (next_state == S_HALT) begin
            illegal_flag <= 1'b1;
        end else begin
            illegal_flag <= illegal_flag;
        end
    end

    assign illegal_op = illegal_flag;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed plus randomized bench for multicycle_controller; expectations come from a per-instruction cycle table.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write;
    logic       mem_write, pc_write, branch, reg_write, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       m2r, rd, iod, sa, irw, mw, pcw, br, rw;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        logic       ill;
    } exp_t;

    exp_t obs;
    assign obs = {mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
                  pc_write, branch, reg_write, alu_src_b, pc_src, alu_control, illegal_op};

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .i_or_d(i_or_d),
        .alu_src_a(alu_src_a), .ir_write(ir_write), .mem_write(mem_write),
        .pc_write(pc_write), .branch(branch), .reg_write(reg_write),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] op);
        case (op)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:            return 3;
            default:                         return 2;
        endcase
    endfunction

    function automatic exp_t idle_exp(input logic ill);
        exp_t e = '0;
        e.ac  = 3'b010;
        e.ill = ill;
        return e;
    endfunction

    // Expected outputs on cycle i of an instruction (cycle 0 is the fetch)
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input int i);
        exp_t e = idle_exp(1'b0);
        if (i == 0) begin
            e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b01;
        end else if (i == 1) begin
            e.sb = 2'b11;
        end else begin
            case (op)
                6'b100011: begin
                    if (i == 2) begin e.sa = 1'b1; e.sb = 2'b10; end
                    else if (i == 3) e.iod = 1'b1;
                    else begin e.m2r = 1'b1; e.rw = 1'b1; end
                end
                6'b101011: begin
                    if (i == 2) begin e.sa = 1'b1; e.sb = 2'b10; end
                    else begin e.iod = 1'b1; e.mw = 1'b1; end
                end
                6'b000000: begin
                    if (i == 2) begin e.sa = 1'b1; e.ac = rtype_alu(fn); end
                    else begin e.rd = 1'b1; e.rw = 1'b1; end
                end
                6'b001000: begin
                    if (i == 2) begin e.sa = 1'b1; e.sb = 2'b10; end
                    else e.rw = 1'b1;
                end
                6'b000100: begin
                    e.sa = 1'b1; e.ps = 2'b01; e.br = 1'b1; e.ac = 3'b110;
                end
                6'b000010: begin
                    e.ps = 2'b10; e.pcw = 1'b1;
                end
                default: e = idle_exp(1'b0);
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input string tag);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < latency(op); i++) begin
            check($sformatf("%s_c%0d", tag, i), model(op, fn, i));
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] legal [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_hold", idle_exp(1'b0));
        end
        @(negedge clk); reset = 1'b0; #1;

        run_instr(6'b100011, 6'b000000, "lw");
        run_instr(6'b000000, 6'b101010, "rtype_slt");
        run_instr(6'b000000, 6'b100100, "rtype_and");
        run_instr(6'b000100, 6'b000000, "beq");
        run_instr(6'b000010, 6'b000000, "jump");
        run_instr(6'b001000, 6'b000000, "addi");

        // sw interrupted by reset while in MEMADR
        opcode = 6'b101011;
        check("swrst_fetch", model(6'b101011, 6'b000000, 0));
        @(posedge clk); #1;
        check("swrst_decode", model(6'b101011, 6'b000000, 1));
        @(posedge clk); #1;
        check("swrst_memadr", model(6'b101011, 6'b000000, 2));
        #2 reset = 1'b1; #1;
        check("swrst_async", idle_exp(1'b0));
        @(posedge clk); #1;
        check("swrst_held", idle_exp(1'b0));
        @(negedge clk); reset = 1'b0; #1;
        check("swrst_refetch", model(6'b101011, 6'b000000, 0));

        for (int n = 0; n < 60; n++) begin
            int k = int'($urandom_range(0, 6));
            int f = int'($urandom_range(0, 5));
            fn = (f == 5) ? 6'($urandom) : functs[f];
`ifdef ILLEGAL_OP_TRAP_EN
            op = legal[k % 6];
`else
            op = (k == 6) ? {2'b11, 4'($urandom)} : legal[k];
`endif
            run_instr(op, fn, $sformatf("rand%0d_op%b", n, op));
        end

        run_instr(6'b111111, 6'b000000, "illegal");
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 12; i++) begin
            check($sformatf("halt_c%0d", i), idle_exp(1'b1));
            @(posedge clk); #1;
        end
        reset = 1'b1; #1;
        check("halt_reset", idle_exp(1'b0));
        @(negedge clk); reset = 1'b0; #1;
`endif
        check("final_fetch", model(6'b000000, 6'b000000, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
